// File: rtl/impl_check_pkg.sv
// Shared types and defaults for the a |-> ##DELAY b implication checker.
package impl_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OK   = 2'd1,
    ST_FAIL = 2'd2
  } status_e;

  localparam int CNT_W_DEF = 16;
  localparam int DELAY_DEF = 1;
  localparam int TS_W      = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (v == {W{1'b1}}) return v;
    return v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/impl_check_monitor.sv
// Synthesizable checker for "a at edge t implies b at edge t+DELAY".
// Optional first-fail timestamp capture is built when IMPL_CHECK_FAIL_TS_EN is defined.
module impl_check_monitor
  import impl_check_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DELAY = DELAY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [1:0]       status
`ifdef IMPL_CHECK_FAIL_TS_EN
  ,
  output logic [TS_W-1:0]  first_fail_ts,
  output logic             first_fail_vld
`endif
);

  logic [DELAY-1:0] vld_p0;
  logic             launch;
  logic             mature;
  logic             pass_evt;
  logic             fail_evt;
  status_e          state_q;
  status_e          state_d;

  assign launch   = en & a;
  assign mature   = vld_p0[DELAY-1];
  // clr discards whatever matures on the same edge
  assign pass_evt = mature & b & ~clr;
  assign fail_evt = mature & ~b & ~clr;

  // Stage 0: attempt shift register, one bit per in-flight attempt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_p0 <= '0;
    else if (clr) vld_p0 <= '0;
    else          vld_p0 <= (vld_p0 << 1) | DELAY'(launch);
  end

  // Stage 1: registered outcome pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
    end else begin
      pass_pulse <= pass_evt;
      fail_pulse <= fail_evt;
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (pass_evt),
    .cnt   (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (fail_evt),
    .cnt   (fail_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FAIL is sticky until clr; OK is only entered from IDLE
  always_comb begin
    state_d = state_q;
    if (clr)                                state_d = ST_IDLE;
    else if (fail_evt)                      state_d = ST_FAIL;
    else if (pass_evt && state_q == ST_IDLE) state_d = ST_OK;
  end

  assign status = state_q;

`ifdef IMPL_CHECK_FAIL_TS_EN
  logic [TS_W-1:0] cyc_q;
  logic [TS_W-1:0] cyc_d;

  assign cyc_d = cyc_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cyc_q <= '0;
    else if (clr) cyc_q <= '0;
    else          cyc_q <= cyc_d;
  end

  // Timestamp is the counter value loaded at the failing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_ts  <= '0;
      first_fail_vld <= 1'b0;
    end else if (clr) begin
      first_fail_ts  <= '0;
      first_fail_vld <= 1'b0;
    end else if (fail_evt && !first_fail_vld) begin
      first_fail_ts  <= cyc_d;
      first_fail_vld <= 1'b1;
    end
  end
`endif

endmodule
